kernel_window_stream: RTL and testbench

- Parametrised successor to the fixed 2x2/stride-2 window generator.
- Accepts a raster-order pixel stream, one pixel per accepted beat, and emits every KxK window at stride S as one flattened bus.
- Adds downstream backpressure, a frame-end flag and back-to-back frame support.
- Sits between the image source and the conv/pool datapath.

---
 rtl/kernel_window_stream_pkg.sv | 17 +
 rtl/kernel_window_stream_if.sv | 23 ++
 rtl/kernel_window_stream_line_buffer.sv | 24 ++
 rtl/kernel_window_stream.sv | 150 +++++++++++++++
 tb/tb_kernel_window_stream.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/kernel_window_stream_pkg.sv
// Shared helpers for the KxK window generator: counter sizing, window slice
// indexing and the number of windows a frame produces.
package kernel_window_stream_pkg;

  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int idx(input int r, input int c, input int k);
    return r * k + c;
  endfunction

  function automatic int frame_windows(input int w, input int h, input int k, input int s);
    return ((w - k) / s + 1) * ((h - k) / s + 1);
  endfunction

endpackage

// File: rtl/kernel_window_stream_if.sv
// Pixel-in / window-out handshake bundle; the block sits on the slave side.
interface kernel_window_stream_if #(
  parameter int DATA_WIDHT = 32,
  parameter int KERNEL     = 2
);
  logic [DATA_WIDHT-1:0]                 Data_In;
  logic                                  Valid_in;
  logic                                  Ready_Out;
  logic                                  Ready_In;
  logic [KERNEL*KERNEL*DATA_WIDHT-1:0]   Data_Out;
  logic                                  Valid_Out;
  logic                                  Frame_Done;

  modport slave (
    input  Data_In, Valid_in, Ready_In,
    output Ready_Out, Data_Out, Valid_Out, Frame_Done
  );

  modport master (
    output Data_In, Valid_in, Ready_In,
    input  Ready_Out, Data_Out, Valid_Out, Frame_Done
  );
endinterface

// File: rtl/kernel_window_stream_line_buffer.sv
// One image row of storage; the read returns the old entry while the same
// address is overwritten on the clock edge (read-before-write).
module line_buffer
  import kernel_window_stream_pkg::*;
#(
  parameter int DEPTH = 220,
  parameter int WIDTH = 32
) (
  input  logic                          clk,
  input  logic                          we,
  input  logic [cnt_width(DEPTH)-1:0]   addr,
  input  logic [WIDTH-1:0]              wr_data,
  output logic [WIDTH-1:0]              rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  assign rd_data = mem[addr];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wr_data;
  end

endmodule

// File: rtl/kernel_window_stream.sv
// Raster pixel stream in, every KxK window at stride S out as one flattened
// bus, behind a one-entry output register with combinational ready.
module kernel_window_stream
  import kernel_window_stream_pkg::*;
#(
  parameter int DATA_WIDHT = 32,
  parameter int IMG_WIDHT  = 220,
  parameter int IMG_HEIGHT = 220,
  parameter int KERNEL     = 2,
  parameter int STRIDE     = 2
) (
  input logic                   clk,
  input logic                   rst,
  kernel_window_stream_if.slave bus
);

  localparam int SAFE_S = (STRIDE < 1) ? 1 : STRIDE;
  localparam int CW     = cnt_width(IMG_WIDHT);
  localparam int RW     = cnt_width(IMG_HEIGHT);
  localparam int PW     = cnt_width(SAFE_S);
  localparam int OW     = KERNEL * KERNEL * DATA_WIDHT;

  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDHT - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
  localparam logic [CW-1:0] COL_DONE = CW'(IMG_WIDHT - 1 - ((IMG_WIDHT - KERNEL) % SAFE_S));
  localparam logic [RW-1:0] ROW_DONE = RW'(IMG_HEIGHT - 1 - ((IMG_HEIGHT - KERNEL) % SAFE_S));
  localparam logic [PW-1:0] PH_LAST  = PW'(SAFE_S - 1);

  if (KERNEL > IMG_WIDHT) begin : g_err_width
    $error("KERNEL larger than IMG_WIDHT");
  end
  if (KERNEL > IMG_HEIGHT) begin : g_err_height
    $error("KERNEL larger than IMG_HEIGHT");
  end
  if (STRIDE < 1 || STRIDE > KERNEL) begin : g_err_stride
    $error("STRIDE outside 1..KERNEL");
  end

  logic                               ready, accept, emit, last_win;
  logic [CW-1:0]                      col, col_nxt;
  logic [RW-1:0]                      row, row_nxt;
  logic [PW-1:0]                      col_ph, col_ph_nxt, row_ph, row_ph_nxt;
  logic [KERNEL-1:0][DATA_WIDHT-1:0]  new_col;
  logic [DATA_WIDHT-1:0]              win     [KERNEL][KERNEL];
  logic [DATA_WIDHT-1:0]              win_nxt [KERNEL][KERNEL];
  logic [OW-1:0]                      data_out, data_out_nxt;
  logic                               valid_out, frame_done;

  assign ready          = !valid_out || bus.Ready_In;
  assign accept         = bus.Valid_in && ready;
  assign bus.Ready_Out  = ready;
  assign bus.Data_Out   = data_out;
  assign bus.Valid_Out  = valid_out;
  assign bus.Frame_Done = frame_done;

  // Rows 0..K-2 of the new column come from the line buffers (oldest first);
  // each buffer passes its old entry down to the next-older one.
  assign new_col[KERNEL-1] = bus.Data_In;

  for (genvar r = 0; r < KERNEL - 1; r++) begin : g_lb
    line_buffer #(
      .DEPTH (IMG_WIDHT),
      .WIDTH (DATA_WIDHT)
    ) u_lb (
      .clk     (clk),
      .we      (accept),
      .addr    (col),
      .wr_data (new_col[r+1]),
      .rd_data (new_col[r])
    );
  end

  always_comb begin
    emit     = (int'(row) >= KERNEL - 1) && (int'(col) >= KERNEL - 1) &&
               (row_ph == '0) && (col_ph == '0);
    last_win = (row == ROW_DONE) && (col == COL_DONE);
  end

  // Phases restart when the counter reaches K-1, so window alignment never
  // depends on what happened earlier in the row or the previous frame.
  always_comb begin
    col_nxt    = col;
    row_nxt    = row;
    col_ph_nxt = col_ph;
    row_ph_nxt = row_ph;
    if (col == COL_LAST) begin
      col_nxt = '0;
      row_nxt = (row == ROW_LAST) ? '0 : row + 1'b1;
    end else begin
      col_nxt = col + 1'b1;
    end
    if (int'(col_nxt) <= KERNEL - 1 || col_ph == PH_LAST) col_ph_nxt = '0;
    else                                                  col_ph_nxt = col_ph + 1'b1;
    if (col == COL_LAST) begin
      if (int'(row_nxt) <= KERNEL - 1 || row_ph == PH_LAST) row_ph_nxt = '0;
      else                                                  row_ph_nxt = row_ph + 1'b1;
    end
  end

  always_comb begin
    data_out_nxt = '0;
    for (int r = 0; r < KERNEL; r++) begin
      for (int c = 0; c < KERNEL - 1; c++) begin
        win_nxt[r][c] = win[r][c+1];
      end
      win_nxt[r][KERNEL-1] = new_col[r];
    end
    for (int r = 0; r < KERNEL; r++) begin
      for (int c = 0; c < KERNEL; c++) begin
        data_out_nxt[idx(r, c, KERNEL)*DATA_WIDHT +: DATA_WIDHT] = win_nxt[r][c];
      end
    end
  end

  // A new window overwrites the output register even while the old one is
  // draining, which is what keeps back-to-back windows bubble-free.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col        <= '0;
      row        <= '0;
      col_ph     <= '0;
      row_ph     <= '0;
      valid_out  <= 1'b0;
      frame_done <= 1'b0;
      data_out   <= '0;
      for (int r = 0; r < KERNEL; r++) begin
        for (int c = 0; c < KERNEL; c++) begin
          win[r][c] <= '0;
        end
      end
    end else begin
      if (accept) begin
        col    <= col_nxt;
        row    <= row_nxt;
        col_ph <= col_ph_nxt;
        row_ph <= row_ph_nxt;
        win    <= win_nxt;
      end
      if (accept && emit) begin
        valid_out  <= 1'b1;
        frame_done <= last_win;
        data_out   <= data_out_nxt;
      end else if (bus.Ready_In) begin
        valid_out  <= 1'b0;
        frame_done <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_kernel_window_stream.sv
// Three parameterisations of kernel_window_stream checked against a
// frame-level window model with randomized pixels, gaps and backpressure.
module tb_kernel_window_stream;

  localparam int DW = 16;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;
  int   done_cnt0;

  logic [DW-1:0]  frame_buf [$];
  logic [143:0]   exp_q0 [$];
  logic [143:0]   exp_q1 [$];
  logic [143:0]   exp_q2 [$];
  bit             exp_d0 [$];
  bit             exp_d1 [$];
  bit             exp_d2 [$];

  kernel_window_stream_if #(.DATA_WIDHT(DW), .KERNEL(2)) bus0 ();
  kernel_window_stream_if #(.DATA_WIDHT(DW), .KERNEL(3)) bus1 ();
  kernel_window_stream_if #(.DATA_WIDHT(DW), .KERNEL(2)) bus2 ();

  kernel_window_stream #(.DATA_WIDHT(DW), .IMG_WIDHT(4), .IMG_HEIGHT(4), .KERNEL(2), .STRIDE(2))
    dut0 (.clk(clk), .rst(rst), .bus(bus0));
  kernel_window_stream #(.DATA_WIDHT(DW), .IMG_WIDHT(5), .IMG_HEIGHT(5), .KERNEL(3), .STRIDE(1))
    dut1 (.clk(clk), .rst(rst), .bus(bus1));
  kernel_window_stream #(.DATA_WIDHT(DW), .IMG_WIDHT(5), .IMG_HEIGHT(5), .KERNEL(2), .STRIDE(2))
    dut2 (.clk(clk), .rst(rst), .bus(bus2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic get_ready(input int sel);
    case (sel)
      0:       return bus0.Ready_Out;
      1:       return bus1.Ready_Out;
      default: return bus2.Ready_Out;
    endcase
  endfunction

  function automatic logic get_valid(input int sel);
    case (sel)
      0:       return bus0.Valid_Out;
      1:       return bus1.Valid_Out;
      default: return bus2.Valid_Out;
    endcase
  endfunction

  task automatic set_in(input int sel, input logic v, input logic [DW-1:0] d);
    case (sel)
      0:       begin bus0.Valid_in = v; bus0.Data_In = d; end
      1:       begin bus1.Valid_in = v; bus1.Data_In = d; end
      default: begin bus2.Valid_in = v; bus2.Data_In = d; end
    endcase
  endtask

  task automatic load_frame(input int n, input int base, input bit rnd);
    frame_buf.delete();
    for (int i = 0; i < n; i++) frame_buf.push_back(rnd ? DW'($urandom) : DW'(base + i));
  endtask

  // Reference: enumerate window origins directly over the stored frame.
  task automatic expect_frame(input int sel, input int w, input int h, input int k, input int s);
    int total, nw;
    logic [143:0] v;
    total = ((w - k) / s + 1) * ((h - k) / s + 1);
    nw = 0;
    for (int wr = 0; wr + k <= h; wr += s) begin
      for (int wc = 0; wc + k <= w; wc += s) begin
        v = '0;
        for (int r = 0; r < k; r++)
          for (int c = 0; c < k; c++)
            v[(r*k + c)*DW +: DW] = frame_buf[(wr + r)*w + wc + c];
        nw++;
        case (sel)
          0:       begin exp_q0.push_back(v); exp_d0.push_back(nw == total); end
          1:       begin exp_q1.push_back(v); exp_d1.push_back(nw == total); end
          default: begin exp_q2.push_back(v); exp_d2.push_back(nw == total); end
        endcase
      end
    end
  endtask

  function automatic bit exp_emit(input int p, input int w, input int k, input int s);
    int r, c;
    r = p / w;
    c = p % w;
    return (r >= k - 1) && (c >= k - 1) && ((r - k + 1) % s == 0) && ((c - k + 1) % s == 0);
  endfunction

  task automatic send_pixel(input int sel, input logic [DW-1:0] v);
    int t;
    set_in(sel, 1'b1, v);
    t = 0;
    @(negedge clk);
    while (!get_ready(sel) && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) check_output("accept_timeout", 160'(get_ready(sel)), 160'd1);
    @(posedge clk);
    #1;
    set_in(sel, 1'b0, v);
  endtask

  task automatic apply_stimulus(input int sel, input int w, input int k, input int s,
                                input int first, input int last, input int gap_pct);
    for (int p = first; p < last; p++) begin
      if (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
        repeat ($urandom_range(2, 1)) @(posedge clk);
        #1;
      end
      send_pixel(sel, frame_buf[p]);
      check_output($sformatf("emit_d%0d_p%0d", sel, p), 160'(get_valid(sel)), 160'(exp_emit(p, w, k, s)));
    end
  endtask

  always @(negedge clk) begin
    if (rst && bus0.Valid_Out && bus0.Ready_In) begin
      if (exp_q0.size() == 0) check_output("d0_extra_window", 160'(bus0.Valid_Out), 160'd0);
      else begin
        check_output("d0_window", 160'(bus0.Data_Out), 160'(exp_q0.pop_front()));
        check_output("d0_frame_done", 160'(bus0.Frame_Done), 160'(exp_d0.pop_front()));
        if (bus0.Frame_Done) done_cnt0++;
      end
    end
  end

  always @(negedge clk) begin
    if (rst && bus1.Valid_Out && bus1.Ready_In) begin
      if (exp_q1.size() == 0) check_output("d1_extra_window", 160'(bus1.Valid_Out), 160'd0);
      else begin
        check_output("d1_window", 160'(bus1.Data_Out), 160'(exp_q1.pop_front()));
        check_output("d1_frame_done", 160'(bus1.Frame_Done), 160'(exp_d1.pop_front()));
      end
    end
  end

  always @(negedge clk) begin
    if (rst && bus2.Valid_Out && bus2.Ready_In) begin
      if (exp_q2.size() == 0) check_output("d2_extra_window", 160'(bus2.Valid_Out), 160'd0);
      else begin
        check_output("d2_window", 160'(bus2.Data_Out), 160'(exp_q2.pop_front()));
        check_output("d2_frame_done", 160'(bus2.Frame_Done), 160'(exp_d2.pop_front()));
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int done_before;
    n_checks  = 0;
    n_fail    = 0;
    done_cnt0 = 0;
    rst = 1'b0;
    bus0.Ready_In = 1'b1; bus1.Ready_In = 1'b1; bus2.Ready_In = 1'b1;
    set_in(0, 1'b0, '0); set_in(1, 1'b0, '0); set_in(2, 1'b0, '0);
    repeat (3) @(posedge clk);
    #1;

    $display("[TB] reset state");
    check_output("rst_valid0", 160'(bus0.Valid_Out), 160'd0);
    check_output("rst_data0",  160'(bus0.Data_Out),  160'd0);
    check_output("rst_done0",  160'(bus0.Frame_Done), 160'd0);
    check_output("rst_ready0", 160'(bus0.Ready_Out), 160'd1);
    check_output("rst_valid1", 160'(bus1.Valid_Out), 160'd0);
    check_output("rst_data1",  160'(bus1.Data_Out),  160'd0);
    check_output("rst_valid2", 160'(bus2.Valid_Out), 160'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] 4x4 K2 S2 pixels 0..15, then a random frame with no bubble");
    load_frame(16, 0, 1'b0);
    expect_frame(0, 4, 4, 2, 2);
    apply_stimulus(0, 4, 2, 2, 0, 6, 0);
    check_output("first_window_literal", 160'(bus0.Data_Out), 160'h0005_0004_0001_0000);
    apply_stimulus(0, 4, 2, 2, 6, 16, 0);
    load_frame(16, 0, 1'b1);
    expect_frame(0, 4, 4, 2, 2);
    apply_stimulus(0, 4, 2, 2, 0, 16, 0);
    repeat (3) @(posedge clk);
    #1;

    $display("[TB] 5x5 K3 S1 pixels 0..24");
    load_frame(25, 0, 1'b0);
    expect_frame(1, 5, 5, 3, 1);
    apply_stimulus(1, 5, 3, 1, 0, 25, 0);
    check_output("k3_last_window_literal", 160'(bus1.Data_Out),
                 160'h0018_0017_0016_0013_0012_0011_000e_000d_000c);
    check_output("k3_last_frame_done", 160'(bus1.Frame_Done), 160'd1);
    repeat (3) @(posedge clk);
    #1;

    $display("[TB] 5x5 K2 S2 random pixels, trailing row/col dropped");
    load_frame(25, 0, 1'b1);
    expect_frame(2, 5, 5, 2, 2);
    apply_stimulus(2, 5, 2, 2, 0, 25, 20);
    repeat (3) @(posedge clk);
    #1;

    $display("[TB] backpressure stall on the first window");
    load_frame(16, 0, 1'b1);
    expect_frame(0, 4, 4, 2, 2);
    bus0.Ready_In = 1'b0;
    apply_stimulus(0, 4, 2, 2, 0, 6, 0);
    set_in(0, 1'b1, frame_buf[6]);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_output("stall_ready", 160'(bus0.Ready_Out), 160'd0);
      check_output("stall_valid", 160'(bus0.Valid_Out), 160'd1);
      check_output("stall_data",  160'(bus0.Data_Out),  160'(exp_q0[0]));
    end
    @(posedge clk);
    #1;
    bus0.Ready_In = 1'b1;
    apply_stimulus(0, 4, 2, 2, 6, 16, 0);
    repeat (3) @(posedge clk);
    #1;

    $display("[TB] two back-to-back frames with random input gaps");
    done_before = done_cnt0;
    for (int f = 0; f < 2; f++) begin
      load_frame(16, 0, 1'b1);
      expect_frame(0, 4, 4, 2, 2);
      apply_stimulus(0, 4, 2, 2, 0, 16, 50);
    end
    repeat (3) @(posedge clk);
    #1;
    check_output("b2b_frame_done_count", 160'(done_cnt0 - done_before), 160'd2);

    $display("[TB] reset in the middle of row 2");
    load_frame(16, 0, 1'b1);
    expect_frame(0, 4, 4, 2, 2);
    apply_stimulus(0, 4, 2, 2, 0, 10, 0);
    rst = 1'b0;
    #1;
    check_output("midrst_valid", 160'(bus0.Valid_Out), 160'd0);
    check_output("midrst_data",  160'(bus0.Data_Out),  160'd0);
    check_output("midrst_done",  160'(bus0.Frame_Done), 160'd0);
    check_output("midrst_pending_windows", 160'(exp_q0.size()), 160'd2);
    exp_q0.delete();
    exp_d0.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    load_frame(16, 100, 1'b0);
    expect_frame(0, 4, 4, 2, 2);
    apply_stimulus(0, 4, 2, 2, 0, 6, 0);
    check_output("post_rst_first_window", 160'(bus0.Data_Out), 160'h0069_0068_0065_0064);
    apply_stimulus(0, 4, 2, 2, 6, 16, 0);
    repeat (4) @(posedge clk);
    #1;

    check_output("q0_drained", 160'(exp_q0.size()), 160'd0);
    check_output("q1_drained", 160'(exp_q1.size()), 160'd0);
    check_output("q2_drained", 160'(exp_q2.size()), 160'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
